// File: rtl/risc_v_chk_pkg.sv
// Shared types for the RISC-V run checker: FSM states, event kinds, fail codes
// and the event-table entry layout.
package risc_v_chk_pkg;

  // Widest monitored bus the table entries can hold; instances use XLEN <= CHK_XLEN.
  localparam int unsigned CHK_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_e;

  typedef enum logic [1:0] {
    EVT_FETCH = 2'd0,
    EVT_STORE = 2'd1,
    EVT_END   = 2'd2
  } evt_kind_e;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd1;
  localparam logic [1:0] FAIL_STORE   = 2'd2;

  typedef struct packed {
    logic [1:0]          kind;
    logic [CHK_XLEN-1:0] addr;
    logic [CHK_XLEN-1:0] data;
  } evt_entry_t;

endpackage

// File: rtl/chk_evt_table.sv
// Expected-event register file: one write port, one combinational read port.
// Contents are deliberately not reset so a run can be repeated after rst.
module chk_evt_table
  import risc_v_chk_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned N_EVT = 8,
  parameter int unsigned IW    = $clog2(N_EVT)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [IW-1:0]   i_widx,
  input  logic [1:0]      i_kind,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_data,
  input  logic [IW-1:0]   i_ridx,
  output evt_entry_t      o_entry_c
);

  evt_entry_t r_mem [N_EVT];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= '{kind: i_kind,
                         addr: CHK_XLEN'(i_addr),
                         data: CHK_XLEN'(i_data)};
    end
  end

  assign o_entry_c = r_mem[i_ridx];

endmodule

// File: rtl/risc_v_run_checker.sv
// In-order commit-trace checker for the single-cycle RISC-V core.
// Build option RUN_CHK_STRICT_STORE_EN: any unmatched store in RUN fails with code 2.
module risc_v_run_checker
  import risc_v_chk_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned N_EVT   = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1),
  parameter int unsigned IW      = $clog2(N_EVT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [1:0]      cfg_kind,
  input  logic [XLEN-1:0] cfg_addr,
  input  logic [XLEN-1:0] cfg_data,
  input  logic [IW:0]     cfg_num,
  input  logic            start,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] wr_data,
  input  logic            mem_wr,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [1:0]      fail_code,
  output logic [IW:0]     evt_ptr,
  output logic [CW-1:0]   cycle_cnt
);

  localparam int unsigned PW = IW + 1;

  chk_state_e    r_state;
  chk_state_e    w_state_nxt;
  logic [PW-1:0] r_num,       w_num_nxt;
  logic [PW-1:0] r_evt_ptr,   w_ptr_nxt;
  logic [CW-1:0] r_cycle_cnt, w_cnt_nxt;
  logic [1:0]    r_fail_code, w_code_nxt;
  logic          r_busy, r_done, r_pass, r_fail;

  evt_entry_t    w_entry;
  logic          w_tbl_we;
  logic          w_hit_fetch, w_hit_store, w_hit;
  logic          w_bad_store;
  logic          w_timeout;
  logic [PW-1:0] w_ptr_inc;

  // The table is frozen while a run is in progress.
  assign w_tbl_we = cfg_we && (r_state != ST_RUN);

  chk_evt_table #(
    .XLEN  (XLEN),
    .N_EVT (N_EVT),
    .IW    (IW)
  ) u_tbl (
    .clk       (clk),
    .i_we      (w_tbl_we),
    .i_widx    (cfg_idx),
    .i_kind    (cfg_kind),
    .i_addr    (cfg_addr),
    .i_data    (cfg_data),
    .i_ridx    (r_evt_ptr[IW-1:0]),
    .o_entry_c (w_entry)
  );

  assign w_hit_fetch = (pc == XLEN'(w_entry.addr)) && (instr == XLEN'(w_entry.data));
  assign w_hit_store = mem_wr && (alu_out == XLEN'(w_entry.addr))
                              && (wr_data == XLEN'(w_entry.data));
  assign w_hit       = (w_entry.kind == EVT_STORE) ? w_hit_store : w_hit_fetch;
  assign w_ptr_inc   = r_evt_ptr + PW'(1);
  assign w_timeout   = (r_cycle_cnt == CW'(TIMEOUT - 1));

`ifdef RUN_CHK_STRICT_STORE_EN
  assign w_bad_store = mem_wr && !w_hit;
`else
  assign w_bad_store = 1'b0;
`endif

  // Next-state: match beats unexpected store, which beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_num_nxt   = r_num;
    w_ptr_nxt   = r_evt_ptr;
    w_cnt_nxt   = r_cycle_cnt;
    w_code_nxt  = r_fail_code;
    case (r_state)
      ST_RUN: begin
        if (r_cycle_cnt != CW'(TIMEOUT)) begin
          w_cnt_nxt = r_cycle_cnt + CW'(1);
        end
        if (w_hit) begin
          w_ptr_nxt = w_ptr_inc;
          if ((w_entry.kind == EVT_END) || (w_ptr_inc == r_num)) begin
            w_state_nxt = ST_PASS;
          end
        end else if (w_bad_store) begin
          w_state_nxt = ST_FAIL;
          w_code_nxt  = FAIL_STORE;
        end else if (w_timeout) begin
          w_state_nxt = ST_FAIL;
          w_code_nxt  = FAIL_TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          w_num_nxt   = cfg_num;
          w_ptr_nxt   = '0;
          w_cnt_nxt   = '0;
          w_code_nxt  = FAIL_NONE;
          w_state_nxt = (cfg_num == '0) ? ST_PASS : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_num       <= '0;
      r_evt_ptr   <= '0;
      r_cycle_cnt <= '0;
      r_fail_code <= FAIL_NONE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_num       <= w_num_nxt;
      r_evt_ptr   <= w_ptr_nxt;
      r_cycle_cnt <= w_cnt_nxt;
      r_fail_code <= w_code_nxt;
      r_busy      <= (w_state_nxt == ST_RUN);
      r_done      <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL);
      r_pass      <= (w_state_nxt == ST_PASS);
      r_fail      <= (w_state_nxt == ST_FAIL);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_fail_code;
  assign evt_ptr   = r_evt_ptr;
  assign cycle_cnt = r_cycle_cnt;

endmodule

// File: doc/risc_v_run_checker.md
# risc_v_run_checker

Synthesizable, parametrised run checker for the single-cycle RISC_V core. It monitors the core's commit-side signals (PC, instr, mem_wr, ALU_out, wr_data) and matches them, in order, against a programmable table of expected fetch and store events. On the first mismatch condition or timeout it reports pass or fail with a cause code. It sits beside the core at top level, so the same check runs in simulation, emulation and on FPGA, replacing free-running display-based checking.

## Interface
- XLEN, 32, data/address width of monitored signals
- N_EVT, 8, event table depth
- TIMEOUT, 1024, RUN cycles allowed before timeout failure
- CW, $clog2(TIMEOUT+1), cycle counter width
- IW, $clog2(N_EVT), table index width

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_idx  in  IW  table entry index
- cfg_kind  in  2  event kind: 0 FETCH, 1 STORE, 2 END
- cfg_addr  in  XLEN  expected PC (FETCH/END) or ALU_out (STORE)
- cfg_data  in  XLEN  expected instr (FETCH/END) or wr_data (STORE)
- cfg_num  in  IW+1  number of valid entries; latched on start
- start  in  1  begin a run
- pc, instr, alu_out, wr_data  in  XLEN  core signals
- mem_wr  in  1  core store strobe
- busy  out  1  state is RUN
- done  out  1  state is PASS or FAIL
- pass  out  1  state is PASS
- fail  out  1  state is FAIL
- fail_code  out  2  0 none, 1 timeout, 2 unexpected store
- evt_ptr  out  IW+1  index of the next expected event (count matched)
- cycle_cnt  out  CW  cycles spent in RUN

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE/PASS/FAIL: cfg_we writes entry cfg_idx. start latches num := cfg_num, clears evt_ptr, cycle_cnt and fail_code, and enters RUN. If cfg_num == 0, start goes directly to PASS.
- RUN: cfg_we and start are ignored. Each cycle, cycle_cnt increments, saturating at TIMEOUT. Only entry[evt_ptr] is compared.
- Match rules:
  - FETCH/END: pc == addr && instr == data.
  - STORE: mem_wr && alu_out == addr && wr_data == data.
- On a match, evt_ptr increments. If the matched entry is END or evt_ptr+1 == num, the next state is PASS.
- Timeout: cycle_cnt == TIMEOUT-1 with no match gives FAIL with code 1.
- Priority in one cycle: match > unexpected store > timeout.
- At most one event is consumed per cycle, even if a later entry also matches.
- rst mid-run: back to IDLE, all outputs 0, num = 0. Table contents are not reset.

## Timing
- Compares use values sampled at the rising clk edge.
- busy rises the cycle after start.
- PASS/FAIL outputs assert the cycle after the deciding sample and hold until the next start or rst.
- A table write is visible to a start issued in the following cycle.
- evt_ptr and cycle_cnt update on the same edge as the state.

## Configuration
- RUN_CHK_STRICT_STORE_EN defined: in RUN, any cycle with mem_wr=1 that does not match entry[evt_ptr] (including when the current entry is FETCH/END) gives FAIL with code 2. Every store must be listed.
- RUN_CHK_STRICT_STORE_EN undefined: unmatched stores are ignored, and fail_code 2 is never produced.

## Structure
- Package risc_v_chk_pkg holds:
  - state enum (IDLE/RUN/PASS/FAIL)
  - event-kind enum (FETCH/STORE/END)
  - fail-code constants
  - table-entry struct {kind, addr, data}
- Sub-module chk_evt_table: N_EVT-entry register file with one write port and one combinational read port indexed by evt_ptr.
- The top module holds the FSM, counters and comparators.

## Test plan
- Table {STORE 0x60/0x2, STORE 0x5c/0x4, FETCH 64/0x00910133, END 72/0x00210063}, cfg_num=4, core running the standard program -> pass=1, evt_ptr=4, fail_code=0.
- Same table, TIMEOUT=16, pc held at 0 -> fail=1 and fail_code=1 exactly 16 cycles after busy rose, evt_ptr=0.
- Strict build, extra store 0x70/0x9 before the 0x60 store -> fail=1, fail_code=2, evt_ptr=0. Non-strict build, same stimulus -> pass=1.
- END match on the same cycle cycle_cnt reaches TIMEOUT-1 -> pass=1 (match wins). cfg_num=0 with start -> pass=1 the next cycle.
- rst asserted mid-run with evt_ptr=2 -> next cycle busy=0, evt_ptr=0, cycle_cnt=0. Restart without rewriting the table -> pass=1.
- cfg_we to entry 0 while busy -> ignored. Run result is unchanged, and entry 0 reads back its old value after done.
